hazard_sequencer: RTL and testbench

- Pipeline hazard controller for the 16-bit five-stage core.
- Generates the per-cycle stall, bubble and flush controls: DHZ/CHZ into the ID/EX pipeline register, write-enables for PC and IF/ID, and a global freeze for memory wait states.
- Sequences the multi-cycle cases: control-redirect flush windows and memory-wait freezes with a timeout.
- Sits beside the ID stage; all inputs come from the IF/ID, ID/EX and EX/MEM stages and the data-memory port.

---
 rtl/hazard_sequencer.sv | 104 ++++++++++
 tb/tb_hazard_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/bubble/flush/freeze control for the five-stage core.
// Define HZ_PERF_CNT_EN to add saturating per-hazard cycle counters.
module hazard_sequencer #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEMWAIT_MAX = 15
`ifdef HZ_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       IDEX_memRead_i,
  input  logic [2:0] IDEX_RTaddr_i,
  input  logic [2:0] IFID_RSaddr_i,
  input  logic [2:0] IFID_RTaddr_i,
  input  logic       IFID_useRT_i,
  input  logic       redirect_i,
  input  logic       mem_req_i,
  input  logic       mem_ready_i,
  output logic       PC_write_o,
  output logic       IFID_write_o,
  output logic       IFID_flush_o,
  output logic       DHZ_o,
  output logic       CHZ_o,
  output logic       freeze_o,
  output logic       timeout_o,
  output logic [1:0] state_o
`ifdef HZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] ldstall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] memwait_cnt_o
`endif
);
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEMWAIT = 2'd2} state_e;
  localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WMAX = 8'(MEMWAIT_MAX);
  state_e state_q, state_d;
  logic resume_q, resume_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic [7:0] wcnt_q, wcnt_d, wcnt_inc;
  logic timeout_q, timeout_d;
  logic mem_wait, in_flush, load_use, wait_done;
  // The ready cycle out of MEMWAIT behaves as the resume state so a held redirect or pending flush is not lost.
  always_comb begin
    mem_wait = mem_req_i & ~mem_ready_i;
    in_flush = (state_q == FLUSH) | ((state_q == MEMWAIT) & resume_q);
    load_use = IDEX_memRead_i & (IDEX_RTaddr_i != 3'd0) &
               ((IDEX_RTaddr_i == IFID_RSaddr_i) | (IFID_useRT_i & (IDEX_RTaddr_i == IFID_RTaddr_i)));
    wcnt_inc = wcnt_q + 8'd1;
    wait_done = wcnt_inc == WMAX;
    freeze_o = mem_wait;
    CHZ_o = ~mem_wait & (in_flush | redirect_i);
    IFID_flush_o = CHZ_o;
    DHZ_o = ~mem_wait & ~CHZ_o & load_use;
    PC_write_o = ~mem_wait & ~DHZ_o;
    IFID_write_o = PC_write_o;
    timeout_o = timeout_q;
    state_o = state_q;
    resume_d = resume_q;
    fcnt_d = fcnt_q;
    wcnt_d = 8'd0;
    timeout_d = timeout_q;
    state_d = RUN;
    if (mem_wait) begin
      resume_d = in_flush;
      wcnt_d = wait_done ? 8'd0 : wcnt_inc;
      timeout_d = timeout_q | wait_done;
      state_d = wait_done ? (in_flush ? FLUSH : RUN) : MEMWAIT;
    end else if (redirect_i) begin
      fcnt_d = RELOAD;
      state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (in_flush) begin
      fcnt_d = (fcnt_q <= 3'd1) ? 3'd0 : fcnt_q - 3'd1;
      state_d = (fcnt_q <= 3'd1) ? RUN : FLUSH;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      resume_q <= 1'b0;
      fcnt_q <= 3'd0;
      wcnt_q <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      resume_q <= resume_d;
      fcnt_q <= fcnt_d;
      wcnt_q <= wcnt_d;
      timeout_q <= timeout_d;
    end
`ifdef HZ_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      ldstall_cnt_o <= '0;
      flush_cnt_o <= '0;
      memwait_cnt_o <= '0;
    end else begin
      if (DHZ_o && !(&ldstall_cnt_o)) ldstall_cnt_o <= ldstall_cnt_o + 1'b1;
      if (CHZ_o && !(&flush_cnt_o)) flush_cnt_o <= flush_cnt_o + 1'b1;
      if (freeze_o && !(&memwait_cnt_o)) memwait_cnt_o <= memwait_cnt_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: scoreboard bench; model tracks owed flush cycles and consecutive wait cycles.
module tb_hazard_sequencer;
  localparam int FC = 3;
  localparam int MW = 15;
  logic clk_i = 1'b0, rst_n = 1'b0;
  logic IDEX_memRead_i = 1'b0, IFID_useRT_i = 1'b0, redirect_i = 1'b0, mem_req_i = 1'b0, mem_ready_i = 1'b0;
  logic [2:0] IDEX_RTaddr_i = 3'd0, IFID_RSaddr_i = 3'd0, IFID_RTaddr_i = 3'd0;
  logic PC_write_o, IFID_write_o, IFID_flush_o, DHZ_o, CHZ_o, freeze_o, timeout_o;
  logic [1:0] state_o;
`ifdef HZ_PERF_CNT_EN
  logic [15:0] ldstall_cnt_o, flush_cnt_o, memwait_cnt_o;
  int m_ld = 0, m_fl = 0, m_mw = 0;
`endif
  int n_chk = 0, n_fail = 0, m_owed = 0, m_wait = 0, cyc_no = 0;
  logic m_to = 1'b0;
  logic [8:0] exp_q[$];

  hazard_sequencer #(.FLUSH_CYCLES(FC), .MEMWAIT_MAX(MW)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .IDEX_memRead_i(IDEX_memRead_i), .IDEX_RTaddr_i(IDEX_RTaddr_i),
    .IFID_RSaddr_i(IFID_RSaddr_i), .IFID_RTaddr_i(IFID_RTaddr_i), .IFID_useRT_i(IFID_useRT_i),
    .redirect_i(redirect_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .PC_write_o(PC_write_o), .IFID_write_o(IFID_write_o), .IFID_flush_o(IFID_flush_o),
    .DHZ_o(DHZ_o), .CHZ_o(CHZ_o), .freeze_o(freeze_o), .timeout_o(timeout_o), .state_o(state_o)
`ifdef HZ_PERF_CNT_EN
    , .ldstall_cnt_o(ldstall_cnt_o), .flush_cnt_o(flush_cnt_o), .memwait_cnt_o(memwait_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outputs from the owed-flush / consecutive-wait view of the hazard rules.
  task automatic cyc(input logic mr, input logic [2:0] rt, input logic [2:0] rs, input logic [2:0] rtid,
                     input logic urt, input logic rd, input logic mq, input logic my);
    logic frz, chz, dhz, lu;
    logic [1:0] st;
    @(posedge clk_i);
    #1;
    {IDEX_memRead_i, IDEX_RTaddr_i, IFID_RSaddr_i, IFID_RTaddr_i} = {mr, rt, rs, rtid};
    {IFID_useRT_i, redirect_i, mem_req_i, mem_ready_i} = {urt, rd, mq, my};
    st = (m_wait > 0) ? 2'd2 : (m_owed > 0) ? 2'd1 : 2'd0;
    frz = mq && !my;
    lu = mr && rt != 3'd0 && (rt == rs || (urt && rt == rtid));
    chz = !frz && (rd || m_owed > 0);
    dhz = !frz && !chz && lu;
    exp_q.push_back({!frz && !dhz, !frz && !dhz, chz, dhz, chz, frz, m_to, st});
`ifdef HZ_PERF_CNT_EN
    m_ld += int'(dhz);
    m_fl += int'(chz);
    m_mw += int'(frz);
`endif
    if (frz) begin
      m_wait++;
      if (m_wait == MW) begin
        m_to = 1'b1;
        m_wait = 0;
      end
    end else begin
      m_wait = 0;
      if (rd) m_owed = FC - 1;
      else if (m_owed > 0) m_owed--;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset;
    @(posedge clk_i);
    #2;
    {IDEX_memRead_i, IDEX_RTaddr_i, IFID_RSaddr_i, IFID_RTaddr_i} = '0;
    {IFID_useRT_i, redirect_i, mem_req_i, mem_ready_i} = '0;
    chk("pre-reset state", 32'(state_o), 32'((m_wait > 0) ? 2 : (m_owed > 0) ? 1 : 0));
    chk("pre-reset CHZ", 32'(CHZ_o), 32'(m_wait == 0 && m_owed > 0));
`ifdef HZ_PERF_CNT_EN
    chk("perf ldstall", 32'(ldstall_cnt_o), 32'(m_ld));
    chk("perf flush", 32'(flush_cnt_o), 32'(m_fl));
    chk("perf memwait", 32'(memwait_cnt_o), 32'(m_mw));
`endif
    rst_n = 1'b0;
    #1;
    chk("async reset state", 32'(state_o), 32'd0);
    chk("async reset CHZ", 32'(CHZ_o), 32'd0);
    chk("async reset timeout", 32'(timeout_o), 32'd0);
`ifdef HZ_PERF_CNT_EN
    chk("perf cleared", 32'({ldstall_cnt_o, flush_cnt_o} | 32'(memwait_cnt_o)), 32'd0);
    {m_ld, m_fl, m_mw} = '0;
`endif
    m_owed = 0;
    m_wait = 0;
    m_to = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic rnd(input int n);
    logic [2:0] rt;
    repeat (n) begin
      rt = 3'($urandom);
      cyc($urandom % 3 == 0, rt, ($urandom % 2 == 1) ? rt : 3'($urandom), ($urandom % 2 == 1) ? rt : 3'($urandom),
          1'($urandom), $urandom % 8 == 0, $urandom % 4 == 0, $urandom % 3 != 0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        cyc_no++;
        chk($sformatf("cycle %0d {pcw,ifw,fl,dhz,chz,frz,to,st}", cyc_no),
            32'({PC_write_o, IFID_write_o, IFID_flush_o, DHZ_o, CHZ_o, freeze_o, timeout_o, state_o}),
            32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1;
    chk("reset defaults", 32'({PC_write_o, IFID_write_o, IFID_flush_o, DHZ_o, CHZ_o, freeze_o, timeout_o, state_o}),
        32'(9'b110000000));
    #13 rst_n = 1'b1;
    idle(1);
    cyc(1, 3, 3, 0, 0, 0, 0, 0);
    cyc(0, 3, 3, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 5, 1, 5, 0, 0, 0, 0);
    cyc(1, 5, 1, 5, 1, 0, 0, 0);
    cyc(1, 3, 3, 0, 0, 1, 0, 0);
    repeat (3) cyc(1, 3, 3, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    repeat (2) cyc(1, 2, 2, 0, 0, 0, 1, 0);
    cyc(1, 2, 2, 0, 0, 0, 1, 1);
    idle(2);
    rnd(300);
    idle(1);
    repeat (MW) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    do_reset();
    idle(2);
    rnd(200);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    do_reset();
    idle(2);
    @(negedge clk_i);
    #1;
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
